// File: rtl/mux_a_pkg.sv
// Shared types and constants for the registered 4:1 bit multiplexer.
// Optional build macro used by this block: MUX_A_HOLD_EN.
package mux_a_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage : mux_a_pkg

// File: rtl/mux_a_dec.sv
// Channel select decoder: turns the 2-bit select into a one-hot channel
// vector, forced to all zeros while the active-low strobe is high.
module mux_a_dec
    import mux_a_pkg::*;
(
    input  logic    g,
    input  sel_t    c,
    output ch_vec_t onehot
);

    // One-hot decode of the select, gated by the active-low strobe
    always_comb begin
        onehot = {NUM_CH{1'b0}};
        if (!g) begin
            case (c)
                2'd0:    onehot = 4'b0001;
                2'd1:    onehot = 4'b0010;
                2'd2:    onehot = 4'b0100;
                2'd3:    onehot = 4'b1000;
                default: onehot = {NUM_CH{1'b0}};
            endcase
        end else begin
            onehot = {NUM_CH{1'b0}};
        end
    end

endmodule : mux_a_dec

// File: rtl/mux_a_reg.sv
// Registered 4:1 single-bit multiplexer with active-low strobe.
// Y, y_valid and sel_q are all flops; nothing reaches Y combinationally.
// Build option MUX_A_HOLD_EN: when G=1, Y and sel_q keep their previous
// values instead of loading 0 and C (y_valid still clears).
module mux_a_reg
    import mux_a_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    G,
    input  sel_t    C,
    input  ch_vec_t X,
    output logic    Y,
    output logic    y_valid,
    output sel_t    sel_q
);

    ch_vec_t onehot_s;
    logic    next_y_s;
    logic    y_r;
    logic    y_valid_r;
    sel_t    sel_r;

    mux_a_dec u_dec (
        .g      (G),
        .c      (C),
        .onehot (onehot_s)
    );

    // Select the addressed bit: mask X with the gated one-hot and OR-reduce
    always_comb begin
        next_y_s = |(onehot_s & X);
    end

    // Output registers; reset wins over any capture on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r       <= RST_VAL;
            y_valid_r <= 1'b0;
            sel_r     <= {SEL_W{1'b0}};
        end else begin
            y_valid_r <= ~G;
            if (!G) begin
                y_r   <= next_y_s;
                sel_r <= C;
            end else begin
`ifdef MUX_A_HOLD_EN
                y_r   <= y_r;
                sel_r <= sel_r;
`else
                y_r   <= 1'b0;
                sel_r <= C;
`endif
            end
        end
    end

    assign Y       = y_r;
    assign y_valid = y_valid_r;
    assign sel_q   = sel_r;

endmodule : mux_a_reg

// File: tb/tb_mux_a_reg.sv
// Self-checking bench for mux_a_reg: a reference model pushes expected
// register contents when stimulus is driven; they are popped and compared
// once the DUT has captured that stimulus.
module tb_mux_a_reg;
    import mux_a_pkg::*;

    typedef struct packed {
        logic y;
        logic v;
        sel_t sel;
    } exp_t;

    logic    clk;
    logic    rst_n;
    logic    G;
    sel_t    C;
    ch_vec_t X;
    logic    Y;
    logic    y_valid;
    sel_t    sel_q;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_err;

    // Model state (tracks what the output registers should hold)
    logic m_y;
    sel_t m_sel;

    mux_a_reg #(.RST_VAL(1'b0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .G       (G),
        .C       (C),
        .X       (X),
        .Y       (Y),
        .y_valid (y_valid),
        .sel_q   (sel_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one set of inputs, predict the capture, push it, then compare
    task automatic drive(input logic g, input sel_t c, input ch_vec_t x, input string tag);
        exp_t e;
        exp_t got;
        G = g;
        C = c;
        X = x;
        if (!g) begin
            m_y   = x[c];
            m_sel = c;
        end else begin
`ifdef MUX_A_HOLD_EN
            m_y   = m_y;
            m_sel = m_sel;
`else
            m_y   = 1'b0;
            m_sel = c;
`endif
        end
        e.y   = m_y;
        e.v   = ~g;
        e.sel = m_sel;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check({tag, "_y"},   {31'd0, Y},       {31'd0, got.y});
            check({tag, "_v"},   {31'd0, y_valid}, {31'd0, got.v});
            check({tag, "_sel"}, {30'd0, sel_q},   {30'd0, got.sel});
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_y   = 1'b0;
        m_sel = 2'd0;

        // Reset asserted from time zero with inputs that would select a 1
        rst_n = 1'b0;
        G     = 1'b0;
        C     = 2'b00;
        X     = 4'b1111;
        #3;
        check("rst_imm_y",   {31'd0, Y},       32'd0);
        check("rst_imm_v",   {31'd0, y_valid}, 32'd0);
        check("rst_imm_sel", {30'd0, sel_q},   32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hold_y", {31'd0, Y},       32'd0);
        check("rst_hold_v", {31'd0, y_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic data path and 1-cycle latency
        drive(1'b0, 2'd0, 4'b0000, "x0");
        drive(1'b0, 2'd0, 4'b0001, "x1");

        // Walk the select across a known pattern
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, sel_t'(i), 4'b1010, "walk");
        end

        // Strobe disabled
        drive(1'b1, 2'd3, 4'b1111, "gdis");

        // Strobe re-enable together with select change
        drive(1'b0, 2'd2, 4'b0100, "gen");

        // Asynchronous reset between edges while Y=1
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_y",   {31'd0, Y},       32'd0);
        check("arst_v",   {31'd0, y_valid}, 32'd0);
        check("arst_sel", {30'd0, sel_q},   32'd0);
        m_y   = 1'b0;
        m_sel = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2'd1, 4'b0010, "post_rst");

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), sel_t'($urandom_range(0, 3)),
                  ch_vec_t'($urandom_range(0, 15)), "rnd");
        end

        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux_a_reg
